// File: rtl/cluster_packer_stream.sv
// Extracts clusters (runs of set S-bits) from one frame, lowest strip first, one word per clock.
// Latency: the first word appears the cycle after the frame is accepted. frame_done follows the last handshake by one cycle.
// Backpressure: a word holds while cluster_valid=1 and cluster_ready=0. sbits_ready is high only in IDLE.
//
// Ports:
//   clock4x, global_reset_n      : clock and asynchronous active-low reset
//   sbits/sbits_valid/sbits_ready: frame input handshake (bit i = strip i); truncate_clusters is sampled with the frame
//   cluster/_valid/_ready/_last  : {cnt=size-1, adr=lowest strip} output stream; last marks the frame's final word
//   frame_done/_nclusters/_overflow: one-cycle per-frame summary
module cluster_packer_stream #(
  parameter int NUM_VFATS      = 24,
  parameter int SBITS_PER_VFAT = 64,
  parameter int MAX_CLUSTERS   = 8,
  parameter int CNT_W          = 3,
  localparam int NSB           = NUM_VFATS * SBITS_PER_VFAT,
  localparam int ADR_W         = $clog2(NSB)
) (
  input  logic                   clock4x,
  input  logic                   global_reset_n,
  input  logic                   truncate_clusters,
  input  logic [NSB-1:0]         sbits,
  input  logic                   sbits_valid,
  output logic                   sbits_ready,
  output logic [CNT_W+ADR_W-1:0] cluster,
  output logic                   cluster_valid,
  input  logic                   cluster_ready,
  output logic                   cluster_last,
  output logic                   frame_done,
  output logic [7:0]             frame_nclusters,
  output logic                   frame_overflow
);

  localparam int CAP = 1 << CNT_W;
  localparam logic [NSB-1:0] ONE = NSB'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NSB-1:0]           mask_q;
  logic                     trunc_q;
  logic [7:0]               cnt_q;
  logic [CNT_W+ADR_W-1:0]   cluster_q;
  logic                     vld_q, last_q;
  logic                     rdy_en_q;

  logic [NSB-1:0]           src_mask, low_bit, run_bits, cap_win, new_mask;
  logic                     src_trunc, any_set, last_nxt, accept, load;
  logic [7:0]               cnt_src, cnt_nxt;
  logic [ADR_W-1:0]         pos;
  logic [CAP-1:0]           seg;
  logic [CNT_W:0]           run_len;
  logic [CNT_W-1:0]         len_f;

  // Cluster extraction. In IDLE it works on the incoming frame so the first
  // word can be registered on the accept edge; in SCAN on the remaining mask.
  always_comb begin
    src_mask  = (state_q == IDLE) ? sbits : mask_q;
    src_trunc = (state_q == IDLE) ? truncate_clusters : trunc_q;
    cnt_src   = (state_q == IDLE) ? 8'd0 : cnt_q;
    any_set   = |src_mask;
    // Isolate the lowest set bit; adding it ripples through the lowest run,
    // so the AND-NOT leaves exactly that run. Carry out of the top bit is
    // dropped, so runs never wrap to strip 0.
    low_bit   = src_mask & (~src_mask + ONE);
    run_bits  = src_mask & ~(src_mask + low_bit);
    // Window of CAP strips starting at the lowest set bit (clipped at the top).
    cap_win   = (low_bit << CAP) - low_bit;
    pos = '0;
    for (int i = NSB - 1; i >= 0; i--) begin
      if (src_mask[i]) pos = ADR_W'(i);
    end
    seg = CAP'(run_bits >> pos);
    run_len = '0;
    for (int j = 0; j < CAP; j++) begin
      run_len = run_len + (CNT_W+1)'(seg[j]);
    end
    len_f    = CNT_W'(run_len - (CNT_W+1)'(1));
    new_mask = src_trunc ? (src_mask & ~run_bits) : (src_mask & ~(run_bits & cap_win));
    cnt_nxt  = cnt_src + 8'd1;
    last_nxt = (new_mask == '0) || (cnt_nxt == 8'(MAX_CLUSTERS));
  end

  assign accept = sbits_valid && sbits_ready;
  // Load a new word on a non-empty accept, or in SCAN when the current
  // (non-final) word is being taken.
  assign load   = (accept && any_set) ||
                  (state_q == SCAN && cluster_ready && !last_q);

  // State register
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = any_set ? SCAN : DONE;
      SCAN:    if (cluster_ready && last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    sbits_ready     = (state_q == IDLE) && rdy_en_q;
    frame_done      = (state_q == DONE);
    frame_nclusters = frame_done ? cnt_q : 8'd0;
    // Bits left in the mask at DONE can only mean the cluster limit cut the frame short.
    frame_overflow  = frame_done && (|mask_q);
    cluster         = cluster_q;
    cluster_valid   = vld_q;
    cluster_last    = last_q;
  end

  // Datapath
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      mask_q    <= '0;
      trunc_q   <= 1'b0;
      cnt_q     <= 8'd0;
      cluster_q <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept) begin
        trunc_q <= truncate_clusters;
        cnt_q   <= 8'd0;
        mask_q  <= '0;
      end
      if (load) begin
        cluster_q <= {len_f, pos};
        vld_q     <= 1'b1;
        last_q    <= last_nxt;
        mask_q    <= new_mask;
        cnt_q     <= cnt_nxt;
      end else if (state_q == SCAN && cluster_ready && last_q) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cluster_packer_stream.sv
module tb_cluster_packer_stream;

  localparam int NV    = 24;
  localparam int SPV   = 64;
  localparam int MAXC  = 8;
  localparam int CNT_W = 3;
  localparam int NSB   = NV * SPV;
  localparam int ADR_W = $clog2(NSB);
  localparam int CAP   = 1 << CNT_W;
  localparam int CW    = CNT_W + ADR_W;

  logic           clock4x;
  logic           global_reset_n;
  logic           truncate_clusters;
  logic [NSB-1:0] sbits;
  logic           sbits_valid;
  logic           sbits_ready;
  logic [CW-1:0]  cluster;
  logic           cluster_valid;
  logic           cluster_ready;
  logic           cluster_last;
  logic           frame_done;
  logic [7:0]     frame_nclusters;
  logic           frame_overflow;

  cluster_packer_stream #(
    .NUM_VFATS(NV), .SBITS_PER_VFAT(SPV), .MAX_CLUSTERS(MAXC), .CNT_W(CNT_W)
  ) dut (
    .clock4x(clock4x), .global_reset_n(global_reset_n),
    .truncate_clusters(truncate_clusters), .sbits(sbits),
    .sbits_valid(sbits_valid), .sbits_ready(sbits_ready),
    .cluster(cluster), .cluster_valid(cluster_valid),
    .cluster_ready(cluster_ready), .cluster_last(cluster_last),
    .frame_done(frame_done), .frame_nclusters(frame_nclusters),
    .frame_overflow(frame_overflow)
  );

  initial clock4x = 1'b0;
  always #5 clock4x = ~clock4x;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model results
  logic [CW-1:0] exp_q[$];
  bit            exp_ovf;

  // Observations of one frame
  logic [CW-1:0] obs_q[$];
  bit            obs_last_q[$];
  int            stab_err, first_cyc, done_cyc, done_hs;
  bit            done_seen, timeout, rdy_at_done, rdy_after, done_after;
  logic [7:0]    done_ncl;
  logic          done_ovf;

  // Walk the strips left to right: each run yields min(run, CAP) strips as a
  // cluster; an over-long run either resumes CAP strips later or is dropped.
  task automatic model(input logic [NSB-1:0] s, input bit tr);
    int i, r, n, len;
    exp_q.delete();
    i = 0;
    n = 0;
    while (i < NSB && n < MAXC) begin
      if (s[i] !== 1'b1) i++;
      else begin
        r = 0;
        while (i + r < NSB && s[i+r] === 1'b1) r++;
        len = (r > CAP) ? CAP : r;
        exp_q.push_back({CNT_W'(len - 1), ADR_W'(i)});
        n++;
        i += (tr || r <= CAP) ? r : CAP;
      end
    end
    exp_ovf = 0;
    for (int j = i; j < NSB; j++) if (s[j]) exp_ovf = 1;
  endtask

  // Offer one frame and record every handshaken word plus the summary.
  // mode 0: ready always 1; 1: pattern 1,0,0,1; 2: random.
  task automatic do_frame(input logic [NSB-1:0] s, input bit tr, input int mode);
    int cyc, hs;
    bit held, rdy;
    logic [CW-1:0] held_w;
    obs_q.delete();
    obs_last_q.delete();
    stab_err = 0; first_cyc = -1; done_cyc = -1; done_hs = -1;
    done_seen = 0; timeout = 0; rdy_at_done = 0; rdy_after = 0; done_after = 0;
    done_ncl = '0; done_ovf = 0;
    cyc = 0;
    while (sbits_ready !== 1'b1 && cyc < 50) begin
      @(negedge clock4x);
      cyc++;
    end
    if (sbits_ready !== 1'b1) begin
      timeout = 1;
      return;
    end
    sbits = s;
    truncate_clusters = tr;
    sbits_valid = 1'b1;
    cluster_ready = (mode == 1) ? 1'b1 : cluster_ready;
    @(posedge clock4x);
    #1;
    sbits_valid = 1'b0;
    sbits = {NSB/32{$urandom}};
    truncate_clusters = $urandom_range(0, 1);
    held = 0;
    hs = 0;
    for (cyc = 1; cyc <= 400 && !done_seen; cyc++) begin
      @(negedge clock4x);
      case (mode)
        0:       rdy = 1;
        1:       rdy = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: rdy = $urandom_range(0, 1);
      endcase
      cluster_ready = rdy;
      if (cluster_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (held && cluster !== held_w) stab_err++;
        if (rdy) begin
          obs_q.push_back(cluster);
          obs_last_q.push_back(cluster_last);
          hs++;
          held = 0;
        end else begin
          held = 1;
          held_w = cluster;
        end
      end
      if (frame_done === 1'b1) begin
        done_seen = 1;
        done_cyc = cyc;
        done_ncl = frame_nclusters;
        done_ovf = frame_overflow;
        done_hs = hs;
        rdy_at_done = sbits_ready;
      end
    end
    if (!done_seen) begin
      timeout = 1;
      return;
    end
    @(negedge clock4x);
    rdy_after = sbits_ready;
    done_after = frame_done;
    cluster_ready = 1'b1;
  endtask

  task automatic test_reset;
    global_reset_n = 1'b0;
    repeat (3) @(negedge clock4x);
    n_cmp++; if (sbits_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", sbits_ready); end
    n_cmp++; if (cluster_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", cluster_valid); end
    n_cmp++; if (cluster !== '0) begin n_fail++; $display("FAIL reset_cluster: got %h expected 0", cluster); end
    n_cmp++; if (cluster_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", cluster_last); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    n_cmp++; if (frame_nclusters !== 8'd0) begin n_fail++; $display("FAIL reset_ncl: got %0d expected 0", frame_nclusters); end
    n_cmp++; if (frame_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", frame_overflow); end
    global_reset_n = 1'b1;
    @(negedge clock4x);
    n_cmp++; if (sbits_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", sbits_ready); end
  endtask

  task automatic test_directed;
    logic [NSB-1:0] v;
    bit tr;
    int tab_ncl[7] = '{1, 3, 2, 1, 8, 0, 3};
    bit tab_ovf[7] = '{0, 0, 0, 0, 1, 0, 0};
    logic [35:0] pat3;
    pat3 = 36'h0ff0ff0ff;
    for (int c = 0; c < 7; c++) begin
      v = '0;
      tr = 0;
      case (c)
        0: v[1:0] = 2'b11;
        1: v[35:0] = pat3;
        2: v[20:5] = '1;
        3: begin v[20:5] = '1; tr = 1; end
        4: v = {(NSB/4){4'h5}};
        5: v = '0;
        default: begin v[0] = 1'b1; v[NSB-1:NSB-10] = '1; end
      endcase
      model(v, tr);
      do_frame(v, tr, 0);
      n_cmp++; if (timeout) begin n_fail++; $display("FAIL dir%0d timeout: got 1 expected 0", c); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL dir%0d nwords: got %0d expected %0d", c, obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL dir%0d word%0d: got %h expected %h", c, k, obs_q[k], exp_q[k]); end
        n_cmp++; if (obs_last_q[k] != (k == exp_q.size() - 1)) begin n_fail++; $display("FAIL dir%0d last%0d: got %b expected %b", c, k, obs_last_q[k], k == exp_q.size() - 1); end
      end
      n_cmp++; if (done_ncl !== 8'(tab_ncl[c])) begin n_fail++; $display("FAIL dir%0d ncl: got %0d expected %0d", c, done_ncl, tab_ncl[c]); end
      n_cmp++; if (done_ovf !== tab_ovf[c]) begin n_fail++; $display("FAIL dir%0d ovf: got %b expected %b", c, done_ovf, tab_ovf[c]); end
      if (tab_ncl[c] > 0) begin
        n_cmp++; if (first_cyc != 1) begin n_fail++; $display("FAIL dir%0d first_word_cycle: got %0d expected 1", c, first_cyc); end
      end
      n_cmp++; if (done_cyc != tab_ncl[c] + 1) begin n_fail++; $display("FAIL dir%0d done_cycle: got %0d expected %0d", c, done_cyc, tab_ncl[c] + 1); end
      n_cmp++; if (rdy_at_done !== 1'b0) begin n_fail++; $display("FAIL dir%0d ready_at_done: got %b expected 0", c, rdy_at_done); end
      n_cmp++; if (rdy_after !== 1'b1 || done_after !== 1'b0) begin n_fail++; $display("FAIL dir%0d after_done: got ready=%b done=%b expected ready=1 done=0", c, rdy_after, done_after); end
    end
  endtask

  task automatic test_backpressure;
    logic [NSB-1:0] v;
    v = {(NSB/4){4'h5}};
    model(v, 0);
    do_frame(v, 0, 1);
    n_cmp++; if (timeout) begin n_fail++; $display("FAIL bp timeout: got 1 expected 0"); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp nwords: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp word%0d: got %h expected %h", k, obs_q[k], exp_q[k]); end
      n_cmp++; if (obs_last_q[k] != (k == exp_q.size() - 1)) begin n_fail++; $display("FAIL bp last%0d: got %b", k, obs_last_q[k]); end
    end
    n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL bp hold_stable: got %0d changes expected 0", stab_err); end
    n_cmp++; if (done_hs != exp_q.size()) begin n_fail++; $display("FAIL bp done_after_handshakes: got %0d expected %0d", done_hs, exp_q.size()); end
    n_cmp++; if (done_ncl !== 8'(exp_q.size()) || done_ovf !== exp_ovf) begin n_fail++; $display("FAIL bp summary: got ncl=%0d ovf=%b expected ncl=%0d ovf=%b", done_ncl, done_ovf, exp_q.size(), exp_ovf); end
  endtask

  task automatic test_random;
    logic [NSB-1:0] v;
    bit tr;
    int dens, st, ln, mode;
    for (int it = 0; it < 30; it++) begin
      v = '0;
      dens = $urandom_range(0, 1) ? $urandom_range(0, 12) : $urandom_range(0, 400);
      for (int i = 0; i < NSB; i++) v[i] = ($urandom_range(0, 999) < dens);
      if ($urandom_range(0, 1)) begin
        st = $urandom_range(0, 1) ? $urandom_range(0, NSB - 1) : $urandom_range(NSB - 25, NSB - 1);
        ln = $urandom_range(1, 24);
        for (int j = 0; j < ln; j++) if (st + j < NSB) v[st+j] = 1'b1;
      end
      tr = $urandom_range(0, 1);
      mode = $urandom_range(0, 2);
      model(v, tr);
      do_frame(v, tr, mode);
      n_cmp++; if (timeout) begin n_fail++; $display("FAIL rnd%0d timeout: got 1 expected 0", it); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d nwords: got %0d expected %0d", it, obs_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        n_cmp++; if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rnd%0d word%0d: got %h expected %h", it, k, obs_q[k], exp_q[k]); end
        n_cmp++; if (obs_last_q[k] != (k == exp_q.size() - 1)) begin n_fail++; $display("FAIL rnd%0d last%0d: got %b", it, k, obs_last_q[k]); end
      end
      n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL rnd%0d hold_stable: got %0d changes expected 0", it, stab_err); end
      n_cmp++; if (done_ncl !== 8'(exp_q.size())) begin n_fail++; $display("FAIL rnd%0d ncl: got %0d expected %0d", it, done_ncl, exp_q.size()); end
      n_cmp++; if (done_ovf !== exp_ovf) begin n_fail++; $display("FAIL rnd%0d ovf: got %b expected %b", it, done_ovf, exp_ovf); end
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [NSB-1:0] v;
    int bad, cyc;
    logic [CW-1:0] want;
    cyc = 0;
    while (sbits_ready !== 1'b1 && cyc < 50) begin @(negedge clock4x); cyc++; end
    cluster_ready = 1'b0;
    sbits = {(NSB/4){4'h5}};
    truncate_clusters = 1'b0;
    sbits_valid = 1'b1;
    @(posedge clock4x);
    #1 sbits_valid = 1'b0;
    repeat (2) @(negedge clock4x);
    n_cmp++; if (cluster_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b expected 1", cluster_valid); end
    global_reset_n = 1'b0;
    #1;
    n_cmp++; if (cluster_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", cluster_valid); end
    bad = 0;
    repeat (3) begin @(negedge clock4x); if (frame_done !== 1'b0) bad++; end
    global_reset_n = 1'b1;
    cluster_ready = 1'b1;
    repeat (3) begin @(negedge clock4x); if (frame_done !== 1'b0) bad++; end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", bad); end
    n_cmp++; if (sbits_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", sbits_ready); end
    v = '0;
    v[NSB-1] = 1'b1;
    want = {CNT_W'(0), ADR_W'(NSB - 1)};
    do_frame(v, 0, 0);
    n_cmp++; if (timeout || obs_q.size() != 1) begin n_fail++; $display("FAIL midrst_nwords: got %0d expected 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== want) begin n_fail++; $display("FAIL midrst_word: got %h expected %h", obs_q[0], want); end
    end
    n_cmp++; if (done_ncl !== 8'd1 || done_ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_summary: got ncl=%0d ovf=%b expected ncl=1 ovf=0", done_ncl, done_ovf); end
  endtask

  initial begin
    global_reset_n = 1'b0;
    truncate_clusters = 1'b0;
    sbits = '0;
    sbits_valid = 1'b0;
    cluster_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
